// File: rtl/clock24_sync.sv
// clock24_sync: 24-hour timekeeping companion to the 12-hour clock.
// Accepts 12-hour loads from the peer clock and 24-hour loads from a
// local setter. It counts seconds/minutes/hours on a 1 Hz tick.
// Local loads are echoed back to the peer in 12-hour form on a one-cycle
// propagate strobe. Peer loads are never echoed, so the two clocks
// cannot ping-pong.

module clock24_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       setEnable,
  input  logic       extern12_propagate,
  input  logic       extern12_isPM,
  input  logic [4:0] extern12_hours,
  input  logic [5:0] extern12_minutes,
  input  logic       set24_propagate,
  input  logic [4:0] set24_hours,
  input  logic [5:0] set24_minutes,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       w_propagate,
  output logic       w_out_isPM,
  output logic [4:0] w_out_hours,
  output logic [5:0] w_out_minutes,
  output logic       day_wrap
);

  // Time-of-day counters
  logic [4:0] hours_q,      hours_d;
  logic [5:0] minutes_q,    minutes_d;
  logic [5:0] seconds_q,    seconds_d;

  // Strobes toward the peer clock and the rollover pulse
  logic       wPropagate_q, wPropagate_d;
  logic       dayWrap_q,    dayWrap_d;

  // 12-hour image of the last local load, held for the peer
  logic       wIsPM_q,      wIsPM_d;
  logic [4:0] wHours_q,     wHours_d;
  logic [5:0] wMinutes_q,   wMinutes_d;

  // Qualified load requests and the count enable
  logic       set24Load;
  logic       extern12Load;
  logic       countEn;

  // 12-hour (isPM, 1..12) to 24-hour (0..23)
  function automatic logic [4:0] to24Hours(input logic isPM, input logic [4:0] h12);
    logic [4:0] result;
    if (h12 == 5'd12) begin
      result = isPM ? 5'd12 : 5'd0;
    end else begin
      result = isPM ? (h12 + 5'd12) : h12;
    end
    return result;
  endfunction

  // 24-hour (0..23) to the 12-hour hour field (1..12)
  function automatic logic [4:0] to12Hours(input logic [4:0] h24);
    logic [4:0] result;
    if (h24 == 5'd0) begin
      result = 5'd12;
    end else if (h24 <= 5'd12) begin
      result = h24;
    end else begin
      result = h24 - 5'd12;
    end
    return result;
  endfunction

  // 24-hour (0..23) to the PM flag
  function automatic logic to12IsPM(input logic [4:0] h24);
    return (h24 >= 5'd12);
  endfunction

  // Strobes carrying out-of-range values are treated as if they never happened
  always_comb begin
    set24Load    = set24_propagate
                   && (set24_hours <= 5'd23)
                   && (set24_minutes <= 6'd59);
    extern12Load = extern12_propagate
                   && (extern12_hours >= 5'd1)
                   && (extern12_hours <= 5'd12)
                   && (extern12_minutes <= 6'd59);
    countEn      = tick && !setEnable && !set24Load && !extern12Load;
  end

  // Next-state selection: local load, then peer load, then tick count
  always_comb begin
    hours_d      = hours_q;
    minutes_d    = minutes_q;
    seconds_d    = seconds_q;
    wPropagate_d = 1'b0;
    dayWrap_d    = 1'b0;
    wIsPM_d      = wIsPM_q;
    wHours_d     = wHours_q;
    wMinutes_d   = wMinutes_q;

    if (set24Load) begin
      hours_d      = set24_hours;
      minutes_d    = set24_minutes;
      seconds_d    = 6'd0;
      wPropagate_d = 1'b1;
      wIsPM_d      = to12IsPM(set24_hours);
      wHours_d     = to12Hours(set24_hours);
      wMinutes_d   = set24_minutes;
    end else if (extern12Load) begin
      hours_d      = to24Hours(extern12_isPM, extern12_hours);
      minutes_d    = extern12_minutes;
      seconds_d    = 6'd0;
    end else if (countEn) begin
      if (seconds_q != 6'd59) begin
        seconds_d = seconds_q + 6'd1;
      end else begin
        seconds_d = 6'd0;
        if (minutes_q != 6'd59) begin
          minutes_d = minutes_q + 6'd1;
        end else begin
          minutes_d = 6'd0;
          if (hours_q != 5'd23) begin
            hours_d = hours_q + 5'd1;
          end else begin
            hours_d   = 5'd0;
            dayWrap_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers with synchronous reset; reset drops any pending strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      hours_q      <= 5'd0;
      minutes_q    <= 6'd0;
      seconds_q    <= 6'd0;
      wPropagate_q <= 1'b0;
      dayWrap_q    <= 1'b0;
      wIsPM_q      <= 1'b0;
      wHours_q     <= 5'd12;
      wMinutes_q   <= 6'd0;
    end else begin
      hours_q      <= hours_d;
      minutes_q    <= minutes_d;
      seconds_q    <= seconds_d;
      wPropagate_q <= wPropagate_d;
      dayWrap_q    <= dayWrap_d;
      wIsPM_q      <= wIsPM_d;
      wHours_q     <= wHours_d;
      wMinutes_q   <= wMinutes_d;
    end
  end

  assign hours         = hours_q;
  assign minutes       = minutes_q;
  assign seconds       = seconds_q;
  assign w_propagate   = wPropagate_q;
  assign w_out_isPM    = wIsPM_q;
  assign w_out_hours   = wHours_q;
  assign w_out_minutes = wMinutes_q;
  assign day_wrap      = dayWrap_q;

endmodule

// File: tb/tb_clock24_sync.sv
// Self-checking bench for clock24_sync.
// A reference model kept as seconds-since-midnight predicts every output.
// Each driven cycle pushes its expectation onto a scoreboard queue. That
// entry is popped and compared once the DUT has clocked.

module tb_clock24_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       setEnable;
  logic       extern12_propagate;
  logic       extern12_isPM;
  logic [4:0] extern12_hours;
  logic [5:0] extern12_minutes;
  logic       set24_propagate;
  logic [4:0] set24_hours;
  logic [5:0] set24_minutes;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       w_propagate;
  logic       w_out_isPM;
  logic [4:0] w_out_hours;
  logic [5:0] w_out_minutes;
  logic       day_wrap;

  typedef struct packed {
    logic       rst;
    logic       tk;
    logic       sen;
    logic       ep;
    logic       epm;
    logic [4:0] eh;
    logic [5:0] em;
    logic       sp;
    logic [4:0] sh;
    logic [5:0] sm;
  } stim_t;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       wProp;
    logic       wPm;
    logic [4:0] wHours;
    logic [5:0] wMinutes;
    logic       dayWrap;
  } expect_t;

  expect_t expectQueue[$];

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state
  int modelSecs  = 0;
  bit modelWProp = 0;
  bit modelWPm   = 0;
  int modelWH    = 12;
  int modelWM    = 0;
  bit modelWrap  = 0;

  clock24_sync dut (
    .clk                (clk),
    .reset              (reset),
    .tick               (tick),
    .setEnable          (setEnable),
    .extern12_propagate (extern12_propagate),
    .extern12_isPM      (extern12_isPM),
    .extern12_hours     (extern12_hours),
    .extern12_minutes   (extern12_minutes),
    .set24_propagate    (set24_propagate),
    .set24_hours        (set24_hours),
    .set24_minutes      (set24_minutes),
    .hours              (hours),
    .minutes            (minutes),
    .seconds            (seconds),
    .w_propagate        (w_propagate),
    .w_out_isPM         (w_out_isPM),
    .w_out_hours        (w_out_hours),
    .w_out_minutes      (w_out_minutes),
    .day_wrap           (day_wrap)
  );

  // Free-running system clock
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Advance the reference model by one clock with the given stimulus
  task automatic modelStep(input stim_t s);
    int h12;
    modelWProp = 0;
    modelWrap  = 0;
    if (s.rst) begin
      modelSecs = 0;
      modelWPm  = 0;
      modelWH   = 12;
      modelWM   = 0;
    end else if (s.sp && int'(s.sh) < 24 && int'(s.sm) < 60) begin
      modelSecs  = int'(s.sh) * 3600 + int'(s.sm) * 60;
      modelWProp = 1;
      modelWPm   = (int'(s.sh) >= 12);
      modelWH    = (int'(s.sh) % 12 == 0) ? 12 : int'(s.sh) % 12;
      modelWM    = int'(s.sm);
    end else if (s.ep && int'(s.eh) >= 1 && int'(s.eh) <= 12 && int'(s.em) < 60) begin
      h12 = (int'(s.eh) % 12) + (s.epm ? 12 : 0);
      modelSecs = h12 * 3600 + int'(s.em) * 60;
    end else if (s.tk && !s.sen) begin
      modelSecs++;
      if (modelSecs == 86400) begin
        modelSecs = 0;
        modelWrap = 1;
      end
    end
  endtask

  // Drive one cycle, push the expectation, then pop and compare after the edge
  task automatic applyStimulus(input stim_t s);
    expect_t e;
    expect_t got;
    @(negedge clk);
    reset              = s.rst;
    tick               = s.tk;
    setEnable          = s.sen;
    extern12_propagate = s.ep;
    extern12_isPM      = s.epm;
    extern12_hours     = s.eh;
    extern12_minutes   = s.em;
    set24_propagate    = s.sp;
    set24_hours        = s.sh;
    set24_minutes      = s.sm;
    modelStep(s);
    e.hours    = 5'(modelSecs / 3600);
    e.minutes  = 6'((modelSecs / 60) % 60);
    e.seconds  = 6'(modelSecs % 60);
    e.wProp    = modelWProp;
    e.wPm      = modelWPm;
    e.wHours   = 5'(modelWH);
    e.wMinutes = 6'(modelWM);
    e.dayWrap  = modelWrap;
    expectQueue.push_back(e);
    @(posedge clk);
    #1;
    if (expectQueue.size() == 0) begin
      checkOutput("queue_empty", 32'd0, 32'd1);
    end else begin
      got = expectQueue.pop_front();
      checkOutput("hours",         32'(hours),         32'(got.hours));
      checkOutput("minutes",       32'(minutes),       32'(got.minutes));
      checkOutput("seconds",       32'(seconds),       32'(got.seconds));
      checkOutput("w_propagate",   32'(w_propagate),   32'(got.wProp));
      checkOutput("w_out_isPM",    32'(w_out_isPM),    32'(got.wPm));
      checkOutput("w_out_hours",   32'(w_out_hours),   32'(got.wHours));
      checkOutput("w_out_minutes", 32'(w_out_minutes), 32'(got.wMinutes));
      checkOutput("day_wrap",      32'(day_wrap),      32'(got.dayWrap));
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic doTicks(input int n, input bit sen);
    stim_t s;
    for (int i = 0; i < n; i++) begin
      s = idleStim();
      s.tk  = 1'b1;
      s.sen = sen;
      applyStimulus(s);
    end
  endtask

  task automatic doIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(idleStim());
  endtask

  task automatic doExtern(input bit pm, input int h, input int m, input bit tk);
    stim_t s;
    s = idleStim();
    s.ep = 1'b1; s.epm = pm; s.eh = 5'(h); s.em = 6'(m); s.tk = tk;
    applyStimulus(s);
  endtask

  task automatic doSet24(input int h, input int m, input bit tk);
    stim_t s;
    s = idleStim();
    s.sp = 1'b1; s.sh = 5'(h); s.sm = 6'(m); s.tk = tk;
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    reset = 1'b1; tick = 1'b0; setEnable = 1'b0;
    extern12_propagate = 1'b0; extern12_isPM = 1'b0;
    extern12_hours = '0; extern12_minutes = '0;
    set24_propagate = 1'b0; set24_hours = '0; set24_minutes = '0;

    // Reset, then three ticks
    s = idleStim(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    doTicks(3, 1'b0);

    // Peer 12-hour loads, converted and never echoed
    doExtern(1'b1, 11, 45, 1'b0);
    doExtern(1'b0, 12, 7, 1'b0);
    doExtern(1'b1, 12, 30, 1'b0);
    doTicks(2, 1'b0);

    // Day rollover from 23:59:59
    doSet24(23, 59, 1'b0);
    doTicks(59, 1'b0);
    doTicks(1, 1'b0);
    doIdle(1);
    doTicks(2, 1'b0);

    // Local loads echoed back in 12-hour form
    doSet24(13, 5, 1'b0);
    doIdle(1);
    doSet24(0, 30, 1'b0);
    doIdle(1);
    doSet24(12, 0, 1'b0);
    doSet24(23, 1, 1'b0);
    doIdle(1);

    // Simultaneous strobes with tick: local wins, invalid local yields to peer
    s = idleStim();
    s.tk = 1'b1; s.sp = 1'b1; s.sh = 5'd8; s.sm = 6'd0;
    s.ep = 1'b1; s.epm = 1'b1; s.eh = 5'd3; s.em = 6'd10;
    applyStimulus(s);
    doIdle(1);
    s.sh = 5'd24;
    applyStimulus(s);
    doIdle(1);

    // Set mode freezes counting but still accepts loads
    doTicks(10, 1'b1);
    s = idleStim();
    s.tk = 1'b1; s.sen = 1'b1; s.ep = 1'b1; s.epm = 1'b0; s.eh = 5'd9; s.em = 6'd15;
    applyStimulus(s);
    doTicks(3, 1'b1);

    // Out-of-range loads are ignored
    doExtern(1'b0, 0, 20, 1'b0);
    doExtern(1'b1, 5, 60, 1'b0);
    doExtern(1'b1, 13, 0, 1'b0);
    doSet24(10, 60, 1'b0);
    doSet24(31, 0, 1'b1);

    // Reset coincident with a local strobe
    doTicks(4, 1'b0);
    s = idleStim();
    s.rst = 1'b1; s.sp = 1'b1; s.sh = 5'd14; s.sm = 6'd22; s.tk = 1'b1;
    applyStimulus(s);
    doIdle(1);
    doTicks(2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/clock24_sync.md
# clock24_sync

24-hour timekeeping block that mirrors the 12-hour clock's propagate interface from the opposite side. It accepts 12-hour time loads (isPM/hours/minutes plus a propagate strobe), converts them to 24-hour form, and keeps counting on a 1 Hz tick. When its own 24-hour setter loads a new time, it drives a 12-hour-encoded propagate strobe back so the 12-hour clock follows. It sits beside the 12-hour clock in the top level; their propagate pairs are cross-connected.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-cycle 1 Hz enable pulse, synchronous to clk
- setEnable  input  1  high = set mode active; counting frozen (tick ignored), loads still accepted
- extern12_propagate  input  1  one-cycle strobe: load time from 12-hour side
- extern12_isPM  input  1  0 = AM, 1 = PM
- extern12_hours  input  5  12-hour hours, valid 1..12
- extern12_minutes  input  6  valid 0..59
- set24_propagate  input  1  one-cycle strobe from local 24-hour setter
- set24_hours  input  5  valid 0..23
- set24_minutes  input  6  valid 0..59
- hours  output  5  current 24-hour hours, 0..23
- minutes  output  6  0..59
- seconds  output  6  0..59
- w_propagate  output  1  one-cycle strobe to 12-hour side after a local (set24) load
- w_out_isPM  output  1  12-hour encoding of loaded time, valid with w_propagate
- w_out_hours  output  5  1..12, valid with w_propagate
- w_out_minutes  output  6  valid with w_propagate
- day_wrap  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover

## Operation
- State: hours/minutes/seconds counters, propagate output register, 12-hour output holding registers.
- Per-cycle priority (highest first): reset, set24 load, extern12 load, tick count.
- set24 load: if set24_hours <= 23 and set24_minutes <= 59, hours/minutes <= inputs, seconds <= 0; 12-hour outputs loaded with converted value; w_propagate asserted. Invalid values: strobe ignored entirely (no load, no w_propagate); a simultaneous valid extern12 strobe then takes effect.
- extern12 load: if 1 <= extern12_hours <= 12 and extern12_minutes <= 59, convert and load, seconds <= 0. Never raises w_propagate (prevents echo loop between clocks). Invalid values ignored.
- 12h -> 24h: 12 AM -> 0; 1..11 AM -> same; 12 PM -> 12; 1..11 PM -> h + 12.
- 24h -> 12h: 0 -> 12 AM; 1..11 -> AM same; 12 -> 12 PM; 13..23 -> PM h - 12.
- Count (tick=1, setEnable=0, no load this cycle): seconds +1; 59 -> 0 with minutes +1; minutes 59 -> 0 with hours +1; hours 23 -> 0 and day_wrap asserted. A tick coinciding with any load is discarded (not deferred).
- w_out_* hold last locally loaded value until the next set24 load; not updated by extern12 loads or counting.

## Timing
- Reset values: hours 0, minutes 0, seconds 0, w_propagate 0, day_wrap 0, w_out_isPM 0, w_out_hours 12, w_out_minutes 0.
- All outputs registered; load or tick in cycle N is visible after clock edge N (i.e., in cycle N+1). One-cycle latency throughout.
- w_propagate and day_wrap are exactly one cycle wide; w_out_* are stable in and after the w_propagate cycle.
- Back-to-back set24 strobes each produce their own w_propagate pulse; w_out_* carry the latest.
- Reset asserted mid-count or coincident with any strobe: reset wins, pending strobe lost, no w_propagate.
- No handshake back-pressure; strobes are fire-and-forget.

## Test plan
- Reset, then 3 ticks -> 00:00:03, w_propagate never high, w_out_hours = 12, w_out_isPM = 0.
- extern12 load PM/11/45 -> next cycle 23:45:00, w_propagate stays 0; then load AM/12/07 -> 00:07:00.
- Set 23:59:59 via set24 load 23:59 plus 59 ticks, then one more tick -> 00:00:00, day_wrap high for exactly one cycle.
- set24 load 13:05 -> next cycle hours 13, minutes 5, seconds 0, w_propagate 1 for one cycle, w_out = PM/1/5; set24 load 0:30 -> w_out = AM/12/30.
- Simultaneous set24 (8:00) and extern12 (PM/3/10) with tick -> 08:00:00, w_propagate 1; repeat with set24 hours 24 -> 15:10:00, w_propagate 0.
- setEnable=1 with 10 ticks -> time unchanged; invalid extern12 hours 0 or minutes 60 -> no change; reset during w_propagate-triggering strobe -> 00:00:00, w_propagate 0.
